// File: rtl/pad_right_ai_if.sv
// Shared game constants, plus the bus between the ball logic and the right-paddle AI.
package vga_pkg;
  localparam int VER_PIXELS = 768;
  localparam logic [1:0] menu_start = 2'd0;
  localparam logic [1:0] play       = 2'd1;
  localparam logic [1:0] game_over  = 2'd2;
endpackage

interface pad_right_ai_if;
  logic        timing_tick;
  logic [1:0]  state;
  logic [10:0] x_ball;
  logic [9:0]  y_ball;
  logic [9:0]  y_pad_right;
  logic [1:0]  ai_state;

  // Ball logic / game side: publishes ball and game state, reads the paddle.
  modport master (
    output timing_tick, state, x_ball, y_ball,
    input  y_pad_right, ai_state
  );

  // AI side: consumes ball and game state, publishes the paddle.
  modport slave (
    input  timing_tick, state, x_ball, y_ball,
    output y_pad_right, ai_state
  );
endinterface

// File: rtl/pad_right_ai.sv
// Computer-controlled right paddle: reacts late, moves at finite speed, ignores
// small errors and drifts back to centre while the ball moves away.
module pad_right_ai #(
  parameter int PAD_HEIGHT   = 145,
  parameter int BALL_SIZE    = 15,
  parameter int PAD_VELOCITY = 2,
  parameter int REACT_TICKS  = 8,
  parameter int DEAD_ZONE    = 4
) (
  input  logic         clk,
  input  logic         rst,
  pad_right_ai_if.slave bus
);
  import vga_pkg::*;

  localparam int HOME  = (VER_PIXELS - PAD_HEIGHT) / 2;
  localparam int Y_MAX = VER_PIXELS - PAD_HEIGHT;
  localparam int CNT_W = $clog2(REACT_TICKS + 1);

  localparam logic signed [10:0] HOME_S  = 11'(HOME);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic signed [10:0] VEL_S   = 11'(PAD_VELOCITY);
  localparam logic signed [11:0] BALL_HALF = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] PAD_HALF  = 12'(PAD_HEIGHT / 2);
  localparam logic signed [11:0] DZ_S      = 12'(DEAD_ZONE);
  localparam logic [CNT_W-1:0]   REACT_C   = CNT_W'(REACT_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RETURN = 2'd1,
    ST_WAIT   = 2'd2,
    ST_TRACK  = 2'd3
  } ai_state_t;

  ai_state_t        fsm;
  logic [9:0]       y_pad;
  logic [CNT_W-1:0] cnt;
  logic [10:0]      x_prev;
  logic             prev_valid;

  logic signed [11:0] err;
  logic signed [10:0] y_s;
  logic signed [10:0] home_diff;
  logic signed [10:0] track_step;
  logic signed [10:0] track_next;
  logic signed [10:0] ret_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               approach;
  logic               recede;

  // Next-position candidates and direction events for the current cycle's ball sample.
  always_comb begin
    y_s        = $signed({1'b0, y_pad});
    err        = $signed({2'b00, bus.y_ball}) + BALL_HALF - $signed({2'b00, y_pad}) - PAD_HALF;
    home_diff  = y_s - HOME_S;
    cnt_inc    = cnt + 1'b1;
    approach   = prev_valid && (bus.x_ball > x_prev);
    recede     = prev_valid && (bus.x_ball < x_prev);

    // Tracking step in the sign of the error, clamped in the signed domain so
    // the 10-bit result can never wrap.
    track_step = y_s;
    if (err > DZ_S)
      track_step = y_s + VEL_S;
    else if (err < -DZ_S)
      track_step = y_s - VEL_S;
    track_next = track_step;
    if (track_step < 11'sd0)
      track_next = 11'sd0;
    else if (track_step > Y_MAX_S)
      track_next = Y_MAX_S;

    // Snap to HOME once within one step so the paddle settles exactly there.
    ret_next = y_s;
    if ((home_diff <= VEL_S) && (home_diff >= -VEL_S))
      ret_next = HOME_S;
    else if (home_diff > 11'sd0)
      ret_next = y_s - VEL_S;
    else
      ret_next = y_s + VEL_S;
  end

  // AI state machine; leaving play overrides any tick activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= ST_IDLE;
      y_pad      <= 10'(HOME);
      cnt        <= '0;
      x_prev     <= '0;
      prev_valid <= 1'b0;
    end else if (bus.state != play) begin
      fsm        <= ST_IDLE;
      y_pad      <= 10'(HOME);
      cnt        <= '0;
      prev_valid <= 1'b0;
    end else if (fsm == ST_IDLE) begin
      fsm        <= ST_RETURN;
      y_pad      <= 10'(HOME);
      cnt        <= '0;
      prev_valid <= 1'b0;
    end else if (bus.timing_tick) begin
      x_prev     <= bus.x_ball;
      prev_valid <= 1'b1;
      case (fsm)
        ST_RETURN: begin
          y_pad <= 10'(ret_next);
          if (approach) begin
            fsm <= ST_WAIT;
            cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (recede) begin
            fsm <= ST_RETURN;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == REACT_C)
              fsm <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          y_pad <= 10'(track_next);
          if (recede)
            fsm <= ST_RETURN;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign bus.y_pad_right = y_pad;
  assign bus.ai_state    = fsm;

endmodule

// File: tb/tb_pad_right_ai.sv
// Directed bench for the right-paddle AI: reset, reaction delay, tracking,
// clamping at both edges, return to centre, leaving play and async reset.
module tb_pad_right_ai;
  import vga_pkg::*;

  logic clk;
  logic rst;
  pad_right_ai_if bus();

  int tests;
  int failed;
  logic [10:0] x;
  int exp_y;

  pad_right_ai dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input integer obs, input integer exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One tick: drive on a falling edge, hold across one rising edge, sample on the next falling edge.
  task automatic do_tick(input logic [10:0] xb, input logic [9:0] yb);
    @(negedge clk);
    bus.x_ball      = xb;
    bus.y_ball      = yb;
    bus.timing_tick = 1'b1;
    @(negedge clk);
    bus.timing_tick = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b0;
    bus.state = menu_start;
    bus.timing_tick = 1'b0;
    bus.x_ball = '0;
    bus.y_ball = '0;

    // Reset values, then ticks outside play are ignored
    #12;
    check("reset_y", bus.y_pad_right, 311);
    check("reset_ai", bus.ai_state, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_tick(11'(100 + 2 * i), 10'd100);
      check("menu_y", bus.y_pad_right, 311);
      check("menu_ai", bus.ai_state, 0);
    end

    // Start from rest: RETURN after one clock, WAIT on second tick, TRACK 8 ticks later
    @(negedge clk);
    bus.state = play;
    @(negedge clk);
    check("start_return", bus.ai_state, 1);
    x = 11'd504;
    do_tick(x, 10'd600);
    check("first_tick_ai", bus.ai_state, 1);
    x = x + 11'd2;
    do_tick(x, 10'd600);
    check("approach_wait", bus.ai_state, 2);
    for (int i = 1; i <= 8; i++) begin
      x = x + 11'd2;
      do_tick(x, 10'd600);
      check("react_ai", bus.ai_state, (i < 8) ? 2 : 3);
      check("react_y", bus.y_pad_right, 311);
    end
    for (int k = 1; k <= 112; k++) begin
      x = x + 11'd2;
      do_tick(x, 10'd600);
      exp_y = (311 + 2 * k > 531) ? 531 : 311 + 2 * k;
      check("track_y", bus.y_pad_right, exp_y);
      check("track_ai", bus.ai_state, 3);
    end

    // Return to home on receding ball
    x = x - 11'd2;
    do_tick(x, 10'd600);
    check("recede_ai", bus.ai_state, 1);
    check("recede_y", bus.y_pad_right, 531);
    for (int k = 1; k <= 112; k++) begin
      x = x - 11'd2;
      do_tick(x, 10'd600);
      exp_y = (531 - 2 * k < 311) ? 311 : 531 - 2 * k;
      check("return_y", bus.y_pad_right, exp_y);
      check("return_ai", bus.ai_state, 1);
    end

    // Receding while waiting goes back to RETURN
    x = x + 11'd2;
    do_tick(x, 10'd600);
    check("wait_again_ai", bus.ai_state, 2);
    x = x - 11'd2;
    do_tick(x, 10'd600);
    check("wait_recede_ai", bus.ai_state, 1);
    check("wait_recede_y", bus.y_pad_right, 311);

    // Clamp at top
    x = x + 11'd2;
    do_tick(x, 10'd0);
    check("top_wait_ai", bus.ai_state, 2);
    for (int i = 1; i <= 8; i++) begin
      x = x + 11'd2;
      do_tick(x, 10'd0);
    end
    check("top_track_ai", bus.ai_state, 3);
    check("top_track_y", bus.y_pad_right, 311);
    for (int k = 1; k <= 160; k++) begin
      x = x + 11'd2;
      do_tick(x, 10'd0);
      exp_y = (311 - 2 * k < 0) ? 0 : 311 - 2 * k;
      check("top_y", bus.y_pad_right, exp_y);
    end

    // Clamp at bottom
    for (int k = 1; k <= 315; k++) begin
      x = x + 11'd1;
      do_tick(x, 10'd753);
      exp_y = (2 * k > 623) ? 623 : 2 * k;
      check("bottom_y", bus.y_pad_right, exp_y);
    end

    // Leaving play mid-TRACK
    @(negedge clk);
    bus.state = game_over;
    @(negedge clk);
    check("gameover_y", bus.y_pad_right, 311);
    check("gameover_ai", bus.ai_state, 0);

    // Back to play, track a little, then async reset between edges
    bus.state = play;
    @(negedge clk);
    check("replay_ai", bus.ai_state, 1);
    x = x + 11'd1;
    do_tick(x, 10'd0);
    x = x + 11'd1;
    do_tick(x, 10'd0);
    check("replay_wait_ai", bus.ai_state, 2);
    for (int i = 1; i <= 8; i++) begin
      x = x + 11'd1;
      do_tick(x, 10'd0);
    end
    for (int k = 1; k <= 3; k++) begin
      x = x + 11'd1;
      do_tick(x, 10'd0);
    end
    check("pre_reset_y", bus.y_pad_right, 305);
    check("pre_reset_ai", bus.ai_state, 3);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_y", bus.y_pad_right, 311);
    check("async_reset_ai", bus.ai_state, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
